// File: rtl/bcd_adder_nd_seq.sv
// N-digit BCD adder: button-driven operand entry FSM feeding a digit-serial (LSD first) add datapath.
// Optional BCD_SUB_EN macro adds nine's-complement subtraction selected by the sub input.
module bcd_adder_nd_seq #(
  parameter int NDIGITS = 2,
  parameter int SELW    = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [4*NDIGITS-1:0]   din,
  input  logic                   cin_sw,
  input  logic                   sub,
  input  logic                   next_btn,
  output logic [4*NDIGITS+3:0]   rslt,
  output logic                   out_of_range,
  output logic                   busy,
  output logic                   done,
  output logic [SELW-1:0]        out_mux_sel,
  output logic [4*NDIGITS-1:0]   a_out,
  output logic [4*NDIGITS-1:0]   b_out,
  output logic                   cin_out
);

`ifdef BCD_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_CIN  = 3'd2,
    S_CALC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  state_t               r_state;
  logic [4*NDIGITS-1:0] r_a;
  logic [4*NDIGITS-1:0] r_b;
  logic                 r_cin;
  logic                 r_sub;
  logic                 r_carry;
  logic [3:0]           r_idx;
  logic [4*NDIGITS+3:0] r_rslt;
  logic                 r_oor;
  logic                 r_busy;
  logic                 r_done;

  // next_btn is a one-cycle strobe with no ready/ack: it is acted on only in the
  // entry/show states, and any strobe arriving during S_CALC is dropped.
  logic       w_sub_req;
  logic       w_cin_eff;
  logic       w_oor;
  logic       w_last;
  logic [3:0] w_a_dig;
  logic [3:0] w_b_raw;
  logic [3:0] w_b_dig;
  logic [4:0] w_sum;
  logic       w_gt9;
  logic [3:0] w_dig;

  function automatic logic any_gt9(input logic [4*NDIGITS-1:0] v);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) r = 1'b1;
    end
    return r;
  endfunction

  assign w_sub_req = SUB_EN & sub;
  assign w_cin_eff = w_sub_req ? 1'b1 : cin_sw;
  assign w_oor     = any_gt9(r_a) | any_gt9(r_b);
  assign w_last    = (r_idx == 4'(NDIGITS-1));

  assign w_a_dig = r_a[int'(r_idx)*4 +: 4];
  assign w_b_raw = r_b[int'(r_idx)*4 +: 4];
  // Subtraction adds the nine's complement of B with a forced carry-in of 1.
  assign w_b_dig = r_sub ? (4'd9 - w_b_raw) : w_b_raw;
  assign w_sum   = {1'b0, w_a_dig} + {1'b0, w_b_dig} + {4'b0, r_carry};
  assign w_gt9   = (w_sum > 5'd9);
  assign w_dig   = w_gt9 ? (w_sum[3:0] + 4'd6) : w_sum[3:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_A;
      r_a     <= '0;
      r_b     <= '0;
      r_cin   <= 1'b0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_rslt  <= '0;
      r_oor   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_A: begin
          if (next_btn) begin
            r_a     <= din;
            r_state <= S_B;
          end
        end
        S_B: begin
          if (next_btn) begin
            r_b     <= din;
            r_state <= S_CIN;
          end
        end
        S_CIN: begin
          if (next_btn) begin
            r_cin  <= w_cin_eff;
            r_sub  <= w_sub_req;
            r_rslt <= '0;
            if (w_oor) begin
              r_oor   <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_SHOW;
            end else begin
              r_oor   <= 1'b0;
              r_idx   <= '0;
              r_carry <= w_cin_eff;
              r_busy  <= 1'b1;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_rslt[int'(r_idx)*4 +: 4] <= w_dig;
          r_carry <= w_gt9;
          r_idx   <= r_idx + 4'd1;
          if (w_last) begin
            r_rslt[4*NDIGITS +: 4] <= {3'b000, w_gt9};
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (next_btn) r_state <= S_A;
        end
        default: r_state <= S_A;
      endcase
    end
  end

  assign rslt         = r_rslt;
  assign out_of_range = r_oor;
  assign busy         = r_busy;
  assign done         = r_done;
  assign out_mux_sel  = SELW'(r_state);
  assign a_out        = r_a;
  assign b_out        = r_b;
  assign cin_out      = r_cin;

endmodule
